dm_rf_alu_ctrl: RTL and testbench
=================================

Name: dm_rf_alu_ctrl

Overview:
- Multi-cycle control unit that sequences the FullDMRFALU datapath (data memory, register file, ALU).
- Accepts one 16-bit instruction per handshake, decodes it, and steps the datapath through EXEC/MEM/WB.
- Drives MemWrite, MemRead, RegWrite, FuncCode, ALUOp, SEin, A, B and sel one state at a time, then reports completion.
- Sits between the instruction source (bench or fetch unit) and FullDMRFALU.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr  in  16  instruction: op[15:12], ra[11:8], rb[7:4], imm_func[3:0].
- instr_ready  out  1  controller can accept.
- MemWrite  out  1  data-memory write strobe.
- MemRead  out  1  data-memory read strobe.
- RegWrite  out  1  register-file write strobe.
- FuncCode  out  4  ALU function (imm_func).
- ALUOp  out  2  00 = add (address calculation), 10 = R-type (use FuncCode).
- SEin  out  16  sign-extended imm_func, i.e. {{12{instr[3]}}, instr[3:0]}.
- A  out  4  register A address (ra).
- B  out  4  register B / destination address (rb).
- sel  out  1  writeback mux select: 1 = memory data, 0 = ALU result.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse on an illegal opcode.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst).
- Reset values:
  - All outputs 0 except instr_ready = 1.
  - State = IDLE.
- Reset mid-operation: the current instruction is abandoned, with no done pulse and no count increment. All strobes are 0 from the next edge.
- States: IDLE, DECODE, EXEC, MEM, WB. All outputs are registered.
- IDLE:
  - instr_ready = 1.
  - On instr_valid && instr_ready, latch instr and go to DECODE. instr_ready falls the next cycle.
- DECODE:
  - Drive A, B, FuncCode, SEin from the latched instruction. These hold until the return to IDLE.
  - op 0000 (R-type), 0001 (LW), 0010 (SW) go to EXEC.
  - Any other op: pulse err and return to IDLE. No strobes, no count increment.
- EXEC:
  - R-type: ALUOp = 10, then go to WB.
  - LW and SW: ALUOp = 00, then go to MEM.
- MEM:
  - LW: MemRead = 1 for exactly one cycle, then go to WB.
  - SW: MemWrite = 1 for exactly one cycle, pulse done, then go to IDLE.
- WB:
  - RegWrite = 1 for one cycle.
  - sel = 1 for LW, 0 for R-type.
  - Pulse done, then go to IDLE.
- Strobe rule: MemRead, MemWrite and RegWrite are never asserted simultaneously. Each is high only in its own state.
- Latency from the accept edge to done (cycles): R-type 3, SW 3, LW 4.
- Back-to-back: a new instruction can be accepted the cycle after done. Throughput = 1 instruction per latency+1 cycles.
- instr_count: increments by 1 on every done pulse and wraps at 2^CNT_W. err does not increment it.
- instr_valid while busy: ignored (no ready). The source must hold the instruction until it is accepted.

Optional Feature:
- Macro: DM_RF_ALU_CTRL_MEM_WAIT_EN.
- Enabled:
  - Adds input mem_ready (1 bit).
  - MEM holds, with its strobe held high, until mem_ready = 1, then advances.
  - If mem_ready is already 1 on entry, timing matches the default.
- Disabled: no mem_ready port; MEM always lasts exactly one cycle.

Decomposition:
- Shared package ctrl_pkg:
  - opcode constants OP_RTYPE, OP_LW, OP_SW;
  - state encoding enum;
  - ALUOp codes ALUOP_ADD, ALUOP_RTYPE.
- One sub-module: dm_rf_alu_decode. Combinational op-to-control decode giving is_rtype, is_lw, is_sw, illegal, and the SEin extension.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst for 2 cycles while instr_valid = 1.
  - During reset: instr_ready = 1, all strobes 0, instr_count = 0.
  - No instruction is accepted until after rst drops.
- R-type: instr = 0x0 3 5 2.
  - ALUOp = 10 in EXEC.
  - RegWrite = 1 with sel = 0, A = 3, B = 5, FuncCode = 2 in WB.
  - done 3 cycles after accept; instr_count = 1.
- LW: instr = 0x1 2 4 F.
  - SEin = 0xFFFF.
  - Sequence: ALUOp = 00 in EXEC, then MemRead one cycle, then RegWrite with sel = 1.
  - done at cycle 4.
- SW then back-to-back R-type:
  - SW: MemWrite one cycle, RegWrite never asserted, done at cycle 3.
  - The R-type is accepted the next cycle; instr_count = 2.
- Illegal op: instr = 0x7000.
  - err pulses in DECODE, no strobes, instr_count unchanged.
- Reset asserted during MEM of an LW:
  - MemRead drops next edge, no done pulse, back in IDLE.
- MEM_WAIT_EN build:
  - mem_ready held low 3 cycles during SW keeps MemWrite high for 4 cycles.
  - done follows in the cycle after mem_ready rises.

Source files
------------

// File: rtl/dm_rf_alu_ctrl_pkg.sv
// ctrl_pkg: shared definitions for the dm_rf_alu_ctrl control unit.
//   - opcode constants (op field, instr[15:12])
//   - ALUOp codes driven to the FullDMRFALU datapath
//   - FSM state encoding
//   - sign-extension helper for the 4-bit imm_func field
package ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    function automatic logic [15:0] sign_ext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage

// File: rtl/dm_rf_alu_decode.sv
// dm_rf_alu_decode: combinational opcode classifier for dm_rf_alu_ctrl.
// Ports:
//   op       in   4   opcode field
//   imm      in   4   imm_func field
//   is_rtype out  1   op is R-type
//   is_lw    out  1   op is load word
//   is_sw    out  1   op is store word
//   illegal  out  1   op is none of the above
//   se       out  16  sign-extended imm
module dm_rf_alu_decode
    import ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [3:0]  imm,
    output logic        is_rtype,
    output logic        is_lw,
    output logic        is_sw,
    output logic        illegal,
    output logic [15:0] se
);

    always_comb begin
        is_rtype = (op == OP_RTYPE);
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        illegal  = !(is_rtype || is_lw || is_sw);
        se       = sign_ext4(imm);
    end

endmodule

// File: rtl/dm_rf_alu_ctrl.sv
// dm_rf_alu_ctrl: multi-cycle controller sequencing the FullDMRFALU datapath
// through DECODE/EXEC/MEM/WB for R-type, LW and SW instructions.
// Optional build macro: DM_RF_ALU_CTRL_MEM_WAIT_EN adds mem_ready, which
// stretches the MEM state (strobe held high) until the memory is ready.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   instr_valid/instr/instr_ready  instruction handshake (16-bit instr)
//   mem_ready       (macro builds only) memory completion
//   MemWrite, MemRead, RegWrite    datapath strobes, mutually exclusive
//   FuncCode, ALUOp, SEin, A, B, sel  datapath controls
//   done, err       one-cycle retire / illegal-opcode pulses
//   instr_count     retired-instruction counter (CNT_W bits, wraps)
module dm_rf_alu_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
`ifdef DM_RF_ALU_CTRL_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             instr_ready,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             RegWrite,
    output logic [3:0]       FuncCode,
    output logic [1:0]       ALUOp,
    output logic [15:0]      SEin,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic             sel,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    state_t      state;
    logic [3:0]  op_q;
    logic [3:0]  dec_op;
    logic        is_rtype, is_lw, is_sw, illegal;
    logic [15:0] dec_se;
    logic        mem_go;

`ifdef DM_RF_ALU_CTRL_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    // In IDLE the decoder looks at the incoming instruction so that err and
    // SEin can be registered on the accept edge and be visible in DECODE;
    // afterwards it classifies the latched opcode.
    always_comb begin
        dec_op = (state == S_IDLE) ? instr[15:12] : op_q;
    end

    dm_rf_alu_decode u_decode (
        .op       (dec_op),
        .imm      (instr[3:0]),
        .is_rtype (is_rtype),
        .is_lw    (is_lw),
        .is_sw    (is_sw),
        .illegal  (illegal),
        .se       (dec_se)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= '0;
            instr_ready <= 1'b1;
            MemWrite    <= 1'b0;
            MemRead     <= 1'b0;
            RegWrite    <= 1'b0;
            FuncCode    <= '0;
            ALUOp       <= ALUOP_ADD;
            SEin        <= '0;
            A           <= '0;
            B           <= '0;
            sel         <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            instr_count <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        op_q        <= instr[15:12];
                        A           <= instr[11:8];
                        B           <= instr[7:4];
                        FuncCode    <= instr[3:0];
                        SEin        <= dec_se;
                        err         <= illegal;
                        instr_ready <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (illegal) begin
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        ALUOp <= is_rtype ? ALUOP_RTYPE : ALUOP_ADD;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_rtype) begin
                        RegWrite <= 1'b1;
                        sel      <= 1'b0;
                        state    <= S_WB;
                    end else begin
                        MemRead  <= is_lw;
                        MemWrite <= is_sw;
                        state    <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (mem_go) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        if (is_lw) begin
                            RegWrite <= 1'b1;
                            sel      <= 1'b1;
                            state    <= S_WB;
                        end else begin
                            ALUOp       <= ALUOP_ADD;
                            done        <= 1'b1;
                            instr_count <= instr_count + 1'b1;
                            instr_ready <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                end
                S_WB: begin
                    RegWrite    <= 1'b0;
                    sel         <= 1'b0;
                    ALUOp       <= ALUOP_ADD;
                    done        <= 1'b1;
                    instr_count <= instr_count + 1'b1;
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_rf_alu_ctrl.sv
// tb_dm_rf_alu_ctrl: self-checking bench for dm_rf_alu_ctrl. Each instruction
// is expanded into the list of phases it must pass through (DEC, EXE, MEM...,
// WB, FIN) and every cycle's outputs are checked against what that phase
// requires. Macro DM_RF_ALU_CTRL_MEM_WAIT_EN adds mem_ready stall testing.
module tb_dm_rf_alu_ctrl;

    typedef enum {P_DEC, P_EXE, P_MEM, P_WB, P_FIN} phase_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        mem_ready;
    logic        instr_ready, MemWrite, MemRead, RegWrite, sel, done, err;
    logic [3:0]  FuncCode, A, B;
    logic [1:0]  ALUOp;
    logic [15:0] SEin;
    logic [15:0] instr_count;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [15:0] model_count;

    always #5 clk = ~clk;

    dm_rf_alu_ctrl #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
`ifdef DM_RF_ALU_CTRL_MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .instr_ready (instr_ready),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .RegWrite    (RegWrite),
        .FuncCode    (FuncCode),
        .ALUOp       (ALUOp),
        .SEin        (SEin),
        .A           (A),
        .B           (B),
        .sel         (sel),
        .done        (done),
        .err         (err),
        .instr_count (instr_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Idle cycle with no offer: must stay ready with everything quiet.
    task automatic idle_cycle;
        instr_valid = 1'b0;
        tick;
        chk("idle_ready", {31'b0, instr_ready}, 1);
        chk("idle_strobes", {29'b0, MemWrite, MemRead, RegWrite}, 0);
        chk("idle_count", {16'b0, instr_count}, {16'b0, model_count});
    endtask

    task automatic do_instr(input logic [15:0] ins, input int unsigned w);
        phase_t      ph[$];
        logic [3:0]  op;
        logic        r, lw, sw, ill;
        logic [15:0] se;
        op  = ins[15:12];
        r   = (op == 4'd0);
        lw  = (op == 4'd1);
        sw  = (op == 4'd2);
        ill = !(r || lw || sw);
        se  = 16'($signed(ins[3:0]));

        ph.push_back(P_DEC);
        if (!ill) begin
            ph.push_back(P_EXE);
            if (lw || sw)
                for (int i = 0; i <= int'(w); i++) ph.push_back(P_MEM);
            if (r || lw) ph.push_back(P_WB);
        end
        ph.push_back(P_FIN);

        chk("ready_pre", {31'b0, instr_ready}, 1);
        instr       = ins;
        instr_valid = 1'b1;
        for (int k = 0; k < ph.size(); k++) begin
            tick;
            if (ph[k] == P_FIN && !ill) model_count = model_count + 16'd1;
            chk("ready", {31'b0, instr_ready}, {31'b0, ph[k] == P_FIN});
            chk("memread", {31'b0, MemRead}, {31'b0, ph[k] == P_MEM && lw});
            chk("memwrite", {31'b0, MemWrite}, {31'b0, ph[k] == P_MEM && sw});
            chk("regwrite", {31'b0, RegWrite}, {31'b0, ph[k] == P_WB});
            chk("done", {31'b0, done}, {31'b0, ph[k] == P_FIN && !ill});
            chk("err", {31'b0, err}, {31'b0, ph[k] == P_DEC && ill});
            chk("count", {16'b0, instr_count}, {16'b0, model_count});
            if (ph[k] != P_FIN) begin
                chk("A", {28'b0, A}, {28'b0, ins[11:8]});
                chk("B", {28'b0, B}, {28'b0, ins[7:4]});
                chk("FuncCode", {28'b0, FuncCode}, {28'b0, ins[3:0]});
                chk("SEin", {16'b0, SEin}, {16'b0, se});
            end
            if (ph[k] == P_EXE) chk("ALUOp", {30'b0, ALUOp}, r ? 32'd2 : 32'd0);
            if (ph[k] == P_WB) chk("sel", {31'b0, sel}, {31'b0, lw});
            if (k + 1 < ph.size()) begin
                // offers while busy must be ignored
                instr_valid = 1'($urandom_range(0, 1));
                instr       = 16'($urandom);
                mem_ready   = !(ph[k] == P_MEM && ph[k+1] == P_MEM);
            end else begin
                instr_valid = 1'b0;
                mem_ready   = 1'b1;
            end
        end
    endtask

    initial begin
        logic [15:0] ins;
        int unsigned w;
        rst         = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'h0352;
        mem_ready   = 1'b1;
        model_count = '0;

        // reset held with an instruction on offer
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("rst_ready", {31'b0, instr_ready}, 1);
            chk("rst_strobes", {29'b0, MemWrite, MemRead, RegWrite}, 0);
            chk("rst_pulses", {30'b0, done, err}, 0);
            chk("rst_count", {16'b0, instr_count}, 0);
        end
        rst = 1'b0;
        idle_cycle;

        // directed plan
        do_instr(16'h0352, 0);
        do_instr(16'h124F, 0);
        idle_cycle;
        do_instr(16'h2A31, 0);
        do_instr(16'h0ABC, 0);
        do_instr(16'h7000, 0);
        idle_cycle;

        // reset during MEM of a load
        instr       = 16'h1368;
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        tick;
        tick;
        chk("lw_mem_read", {31'b0, MemRead}, 1);
        rst = 1'b1;
        tick;
        model_count = '0;
        chk("rst_mid_memread", {31'b0, MemRead}, 0);
        chk("rst_mid_done", {31'b0, done}, 0);
        chk("rst_mid_ready", {31'b0, instr_ready}, 1);
        chk("rst_mid_count", {16'b0, instr_count}, 0);
        rst = 1'b0;
        idle_cycle;
        chk("rst_mid_nodone", {30'b0, done, RegWrite}, 0);

`ifdef DM_RF_ALU_CTRL_MEM_WAIT_EN
        do_instr(16'h2F0F, 3);
        do_instr(16'h1221, 2);
`endif

        // randomized traffic, mixing back-to-back and gapped issue
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: ins = {4'd0, 12'($urandom)};
                1: ins = {4'd1, 12'($urandom)};
                2: ins = {4'd2, 12'($urandom)};
                default: ins = {4'($urandom_range(3, 15)), 12'($urandom)};
            endcase
`ifdef DM_RF_ALU_CTRL_MEM_WAIT_EN
            w = $urandom_range(0, 3);
`else
            w = 0;
`endif
            do_instr(ins, w);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
